// File: rtl/sha2_ctrl_pkg.sv
// Shared definitions for the SHA-2 host controller: FSM encoding, LED bit
// positions and default sizing parameters.
package sha2_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    SEND  = 3'd4
  } state_e;

  localparam int LED_BUSY    = 0;
  localparam int LED_OVERRUN = 1;
  localparam int LED_RX_ERR  = 2;
  localparam int LED_TIMEOUT = 3;
  localparam int LED_CNT_LSB = 4;

  localparam int DEF_BLOCK_BYTES    = 64;
  localparam int DEF_DIGEST_BYTES   = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/sha2_byte_serializer.sv
// Holds the latched digest and streams it MSB byte first to a UART, keeping
// at most one byte in flight via a pending flag.
module sha2_byte_serializer
  import sha2_ctrl_pkg::*;
#(
  parameter int DIGEST_BYTES = DEF_DIGEST_BYTES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_i,
  input  logic [DIGEST_BYTES*8-1:0] digest_i,
  input  logic                      tx_busy_i,
  output logic                      tx_start_o,
  output logic [7:0]                tx_byte_o,
  output logic                      done_o
);

  localparam int IW = $clog2(DIGEST_BYTES + 1);

  logic [DIGEST_BYTES*8-1:0] digest_q, digest_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      active_q, active_d;
  logic                      pend_q, pend_d;
  logic [1:0]                age_q, age_d;
  logic                      all_sent;

  assign all_sent   = (idx_q == IW'(DIGEST_BYTES));
  assign tx_start_o = active_q && !pend_q && !tx_busy_i && !all_sent;
  assign done_o     = active_q && !pend_q && all_sent;

  always_comb begin
    tx_byte_o = '0;
    for (int k = 0; k < DIGEST_BYTES; k++) begin
      if (idx_q == IW'(k)) tx_byte_o = digest_q[(DIGEST_BYTES-k)*8-1 -: 8];
    end
  end

  // A sent byte stays pending until tx_busy is seen low at least two cycles
  // after its tx_start, which covers the UART's busy-flag latency.
  always_comb begin
    digest_d = digest_q;
    idx_d    = idx_q;
    active_d = active_q;
    pend_d   = pend_q;
    age_d    = age_q;
    if (load_i) begin
      digest_d = digest_i;
      idx_d    = '0;
      active_d = 1'b1;
      pend_d   = 1'b0;
      age_d    = '0;
    end else begin
      if (tx_start_o) begin
        pend_d = 1'b1;
        age_d  = 2'd1;
        idx_d  = idx_q + 1'b1;
      end else if (pend_q) begin
        if (age_q == 2'd2 && !tx_busy_i) begin
          pend_d = 1'b0;
          age_d  = '0;
        end else if (age_q != 2'd2) begin
          age_d = age_q + 2'd1;
        end
      end
      if (done_o) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digest_q <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      pend_q   <= 1'b0;
      age_q    <= '0;
    end else begin
      digest_q <= digest_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      age_q    <= age_d;
    end
  end

endmodule

// File: rtl/sha2_host_ctrl.sv
// UART-to-SHA-2 host controller: assembles a message block from received bytes,
// hands it to the core and returns the digest. Optional RECV inter-byte
// timeout is enabled by defining SHA2_RX_TIMEOUT_EN.
module sha2_host_ctrl
  import sha2_ctrl_pkg::*;
#(
  parameter int BLOCK_BYTES    = DEF_BLOCK_BYTES,
  parameter int DIGEST_BYTES   = DEF_DIGEST_BYTES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_byte,
  input  logic                      rx_error,
  output logic                      tx_start,
  output logic [7:0]                tx_byte,
  input  logic                      tx_busy,
  output logic [BLOCK_BYTES*8-1:0]  block_data,
  output logic                      block_valid,
  input  logic                      block_ready,
  input  logic [DIGEST_BYTES*8-1:0] digest_data,
  input  logic                      digest_valid,
  output logic [7:0]                led
);

  localparam int CW = $clog2(BLOCK_BYTES + 1);

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [BLOCK_BYTES*8-1:0] block_q, block_d;
  logic                     overrun_q, overrun_d;
  logic                     rxerr_q, rxerr_d;
  logic                     timeout_q, timeout_d;
  logic [3:0]               done_cnt_q, done_cnt_d;
  logic                     rx_take;
  logic                     wr_en;
  logic [CW-1:0]            wr_idx;
  logic                     digest_load;
  logic                     ser_done;
  logic                     gap_hit;

  // A framing error in the same cycle always wins over the received byte.
  assign rx_take = rx_valid && !rx_error;

`ifdef SHA2_RX_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  logic [GW-1:0] gap_q, gap_d;

  always_comb begin
    gap_d = '0;
    if (state_q == RECV && !rx_valid) gap_d = gap_q + 1'b1;
  end

  assign gap_hit = (state_q == RECV) && (gap_q == GW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_q <= '0;
    else        gap_q <= gap_d;
  end
`else
  assign gap_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    block_d     = block_q;
    overrun_d   = overrun_q;
    rxerr_d     = rxerr_q | rx_error;
    timeout_d   = timeout_q;
    done_cnt_d  = done_cnt_q;
    wr_en       = 1'b0;
    wr_idx      = cnt_q;
    digest_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_take) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          cnt_d   = CW'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (rx_error) begin
          block_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (rx_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(BLOCK_BYTES - 1)) state_d = ISSUE;
        end else if (gap_hit) begin
          block_d   = '0;
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      ISSUE: begin
        if (block_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (digest_valid) begin
          digest_load = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (ser_done) begin
          done_cnt_d = done_cnt_q + 4'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bytes arriving while a block is in flight are dropped and flagged.
    if (rx_take && (state_q == ISSUE || state_q == WAIT || state_q == SEND))
      overrun_d = 1'b1;

    if (wr_en) begin
      for (int k = 0; k < BLOCK_BYTES; k++) begin
        if (wr_idx == CW'(k)) block_d[(BLOCK_BYTES-k)*8-1 -: 8] = rx_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      block_q    <= '0;
      overrun_q  <= 1'b0;
      rxerr_q    <= 1'b0;
      timeout_q  <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      block_q    <= block_d;
      overrun_q  <= overrun_d;
      rxerr_q    <= rxerr_d;
      timeout_q  <= timeout_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  sha2_byte_serializer #(
    .DIGEST_BYTES(DIGEST_BYTES)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (digest_load),
    .digest_i  (digest_data),
    .tx_busy_i (tx_busy),
    .tx_start_o(tx_start),
    .tx_byte_o (tx_byte),
    .done_o    (ser_done)
  );

  assign block_valid = (state_q == ISSUE);
  assign block_data  = block_q;

  always_comb begin
    led = '0;
    led[LED_BUSY]          = (state_q != IDLE);
    led[LED_OVERRUN]       = overrun_q;
    led[LED_RX_ERR]        = rxerr_q;
    led[LED_TIMEOUT]       = timeout_q;
    led[LED_CNT_LSB +: 4]  = done_cnt_q;
  end

endmodule

// File: tb/tb_sha2_host_ctrl.sv
// Directed self-checking bench for sha2_host_ctrl; the timeout expectations
// follow whether SHA2_RX_TIMEOUT_EN is defined.
module tb_sha2_host_ctrl;

  localparam int BB = 64;
  localparam int DB = 32;

  logic          clk;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          rx_error;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          tx_busy;
  logic [BB*8-1:0] block_data;
  logic          block_valid;
  logic          block_ready;
  logic [DB*8-1:0] digest_data;
  logic          digest_valid;
  logic [7:0]    led;

  int numCompared;
  int numMismatched;
  int busyCnt;
  int txCount;
  int protoErrs;
  logic [7:0] txLog [0:1023];

  sha2_host_ctrl #(
    .BLOCK_BYTES   (BB),
    .DIGEST_BYTES  (DB),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .rx_error    (rx_error),
    .tx_start    (tx_start),
    .tx_byte     (tx_byte),
    .tx_busy     (tx_busy),
    .block_data  (block_data),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .digest_data (digest_data),
    .digest_valid(digest_valid),
    .led         (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART model: busy for 10 cycles after each accepted tx_start.
  always @(posedge clk) begin
    if (tx_start)         busyCnt <= 10;
    else if (busyCnt > 0) busyCnt <= busyCnt - 1;
  end
  assign tx_busy = (busyCnt != 0);

  always @(negedge clk) begin
    if (tx_start) begin
      if (txCount < 1024) txLog[txCount] = tx_byte;
      if (tx_busy) protoErrs++;
      txCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    numCompared++;
    if (obs !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulseError(input logic withByte);
    @(negedge clk);
    rx_error = 1'b1;
    rx_valid = withByte;
    rx_byte  = 8'h77;
    @(negedge clk);
    rx_error = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic sendBlock(input logic [7:0] base);
    for (int k = 0; k < BB; k++) applyStimulus(8'(base + k));
  endtask

  task automatic acceptBlock();
    @(negedge clk);
    block_ready = 1'b1;
    repeat (5) @(negedge clk);
    block_ready = 1'b0;
  endtask

  task automatic sendDigest(input logic [DB*8-1:0] d);
    @(negedge clk);
    digest_valid = 1'b1;
    digest_data  = d;
    @(negedge clk);
    digest_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (led[0] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 512'(led[0]), 512'(0));
  endtask

  task automatic runFlow(input logic [7:0] base);
    sendBlock(base);
    acceptBlock();
    sendDigest({DB{8'h3C}});
    waitIdle("flow_idle");
  endtask

  logic [BB*8-1:0] expBlock;
  logic [DB*8-1:0] digest2;
  int txBase;

  initial begin
    numCompared   = 0;
    numMismatched = 0;
    busyCnt       = 0;
    txCount       = 0;
    protoErrs     = 0;
    rst_n         = 1'b0;
    rx_valid      = 1'b0;
    rx_byte       = '0;
    rx_error      = 1'b0;
    block_ready   = 1'b0;
    digest_data   = '0;
    digest_valid  = 1'b0;

    #12;
    checkOutput("rst_led", 512'(led), 512'(0));
    checkOutput("rst_block_valid", 512'(block_valid), 512'(0));
    checkOutput("rst_block_data", 512'(block_data), 512'(0));
    checkOutput("rst_tx", 512'({tx_start, tx_byte}), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] block 1: bytes 00..3F");
    applyStimulus(8'h00);
    checkOutput("busy_recv", 512'(led[0]), 512'(1));
    for (int k = 1; k < BB; k++) applyStimulus(8'(k));
    for (int k = 0; k < BB; k++) expBlock[(BB-k)*8-1 -: 8] = 8'(k);
    checkOutput("issue_valid", 512'(block_valid), 512'(1));
    checkOutput("issue_data", 512'(block_data), 512'(expBlock));
    repeat (3) @(negedge clk);
    checkOutput("issue_hold_valid", 512'(block_valid), 512'(1));
    checkOutput("issue_hold_data", 512'(block_data), 512'(expBlock));
    acceptBlock();
    checkOutput("wait_valid_low", 512'(block_valid), 512'(0));
    checkOutput("wait_busy", 512'(led[0]), 512'(1));

    txBase = txCount;
    sendDigest({DB{8'hA5}});
    waitIdle("send1_idle");
    checkOutput("send1_count", 512'(txCount - txBase), 512'(DB));
    for (int j = 0; j < DB; j++) checkOutput("send1_byte", 512'(txLog[txBase+j]), 512'(8'hA5));
    checkOutput("led_after_1", 512'(led), 512'(8'h10));

    txBase = txCount;
    sendDigest({DB{8'h11}});
    repeat (5) @(negedge clk);
    checkOutput("digest_idle_ignored", 512'({led[0], 8'(txCount - txBase)}), 512'(0));

    $display("[TB] abort after 17 bytes, then fresh block");
    pulseError(1'b1);
    checkOutput("err_with_byte_idle", 512'(led[0]), 512'(0));
    for (int k = 0; k < 17; k++) applyStimulus(8'hEE);
    pulseError(1'b0);
    checkOutput("abort_led", 512'(led[2:0]), 512'(3'b100));
    sendBlock(8'h40);
    for (int k = 0; k < BB; k++) expBlock[(BB-k)*8-1 -: 8] = 8'(8'h40 + k);
    checkOutput("fresh_data", 512'(block_data), 512'(expBlock));
    acceptBlock();
    applyStimulus(8'hFF);
    checkOutput("overrun_led", 512'(led[1:0]), 512'(2'b11));
    checkOutput("overrun_block", 512'(block_data), 512'(expBlock));

    for (int j = 0; j < DB; j++) digest2[(DB-j)*8-1 -: 8] = 8'(8'h80 + j);
    txBase = txCount;
    sendDigest(digest2);
    waitIdle("send2_idle");
    checkOutput("send2_count", 512'(txCount - txBase), 512'(DB));
    for (int j = 0; j < DB; j++) checkOutput("send2_order", 512'(txLog[txBase+j]), 512'(8'h80 + j));
    checkOutput("led_after_2", 512'(led[7:4]), 512'(2));

    $display("[TB] rx gap of 100 cycles");
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    repeat (100) @(posedge clk);
    @(negedge clk);
`ifdef SHA2_RX_TIMEOUT_EN
    checkOutput("timeout_led", 512'({led[3], led[0]}), 512'(2'b10));
`else
    checkOutput("no_timeout_led", 512'({led[3], led[0]}), 512'(2'b01));
`endif
    pulseError(1'b0);
    checkOutput("gap_exit_idle", 512'(led[0]), 512'(0));

    $display("[TB] reset during SEND");
    sendBlock(8'h10);
    acceptBlock();
    txBase = txCount;
    sendDigest({DB{8'h5A}});
    begin
      int n;
      n = 0;
      while ((txCount - txBase) < 12 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      checkOutput("reached_byte12", 512'(txCount - txBase >= 12), 512'(1));
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_led", 512'(led), 512'(0));
    checkOutput("midrst_tx", 512'({tx_start, tx_byte}), 512'(0));
    checkOutput("midrst_block", 512'({block_valid, block_data}), 512'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] 16 completed blocks");
    for (int b = 0; b < 15; b++) runFlow(8'(b));
    checkOutput("count_15", 512'(led[7:4]), 512'(15));
    runFlow(8'h20);
    checkOutput("count_wrap", 512'(led[7:4]), 512'(0));
    checkOutput("tx_while_busy", 512'(protoErrs), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/sha2_host_ctrl.md
SHA2_HOST_CTRL -- requirements
Module: sha2_host_ctrl

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 64: message-block length in bytes; legal range 4..128.
REQ-002 SHALL have parameter DIGEST_BYTES, default 32: digest length in bytes; legal range 4..64.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum inter-byte gap in RECV.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: rx_valid  in  1  one-cycle pulse, byte received; rx_byte  in  8  received byte; rx_error  in  1  one-cycle pulse, UART framing error.
REQ-006 SHALL have ports: tx_start  out  1  one-cycle request to send a byte; tx_byte  out  8  byte to send; tx_busy  in  1  UART transmitting.
REQ-007 SHALL have ports: block_data  out  BLOCK_BYTES*8  assembled block; block_valid  out  1  block offered; block_ready  in  1  core accepts.
REQ-008 SHALL have ports: digest_data  in  DIGEST_BYTES*8  core result; digest_valid  in  1  one-cycle pulse, result ready.
REQ-009 SHALL have port led  out  8  status: [0] busy, [1] overrun, [2] rx error, [3] timeout, [7:4] completed-block count mod 16.

Function
REQ-010 SHALL implement FSM states IDLE, RECV, ISSUE, WAIT, SEND.
REQ-011 IDLE: first rx_valid SHALL store the byte as byte 0 and enter RECV.
REQ-012 Byte k SHALL occupy block_data[(BLOCK_BYTES-k)*8-1 -: 8] (first byte in the MSBs).
REQ-013 Byte counter SHALL be $clog2(BLOCK_BYTES+1) bits; the byte that completes the block SHALL enter ISSUE on the next edge.
REQ-014 ISSUE: block_valid SHALL be high; block_data SHALL be stable; the FSM SHALL enter WAIT on the cycle block_valid && block_ready.
REQ-015 WAIT: digest_valid SHALL latch digest_data into an internal register and enter SEND; digest_valid in any other state SHALL be ignored.
REQ-016 SEND: digest bytes SHALL go out MSB byte first, exactly DIGEST_BYTES tx_start pulses.
REQ-017 tx_start SHALL be issued only when tx_busy is low and no byte is pending; a byte is pending from its tx_start until tx_busy is sampled low on a cycle at least 2 cycles after that tx_start.
REQ-018 SEND SHALL return to IDLE when the last byte is no longer pending; led[7:4] SHALL then increment and wrap 15->0.
REQ-019 rx_valid in ISSUE, WAIT or SEND SHALL be dropped and SHALL set led[1] (sticky).
REQ-020 rx_error in RECV SHALL discard the partial block, zero the counter, set led[2] (sticky) and enter IDLE; in other states it SHALL only set led[2].
REQ-021 rx_valid and rx_error in the same cycle: the error SHALL win and the byte SHALL be discarded.
REQ-022 led[0] SHALL be high in every state except IDLE.
REQ-023 Sticky flags SHALL clear only on reset.

Reset
REQ-024 On rst_n low, the FSM SHALL enter IDLE asynchronously, including mid-block and mid-SEND.
REQ-025 On rst_n low, the following SHALL be 0: tx_start, tx_byte, block_valid, block_data, led, counters, digest register, pending flag.
REQ-026 Reset release SHALL be synchronised by the instantiating top; the block SHALL be ready for rx_valid one cycle after release.

Configuration
REQ-027 With SHA2_RX_TIMEOUT_EN defined, a gap counter SHALL run in RECV and reset on each rx_valid.
REQ-028 With SHA2_RX_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL discard the partial block, set led[3] (sticky) and enter IDLE.
REQ-029 Without SHA2_RX_TIMEOUT_EN, there SHALL be no gap counter, led[3] SHALL be constant 0, and RECV SHALL wait indefinitely.

Structure
REQ-030 Package sha2_ctrl_pkg SHALL hold the FSM state encoding, LED bit-index constants and parameter defaults.
REQ-031 Sub-module sha2_byte_serializer SHALL own the digest register, the MSB-first byte selection and the tx_start/tx_busy pending handshake.

Verification
REQ-032 BLOCK_BYTES=64, DIGEST_BYTES=32, bytes 0x00..0x3F sent -> block_data=0x0001...3F, block_valid high; block_ready held 5 cycles -> WAIT.
REQ-033 digest_valid with digest 0xA5A5...A5, tx_busy modelled high for 10 cycles per byte -> exactly 32 tx_start pulses, each tx_byte=0xA5, then IDLE with led[7:4]=1.
REQ-034 rx_error after 17 bytes -> IDLE, led[2]=1; then 64 fresh bytes -> correct block with no residue from the aborted block.
REQ-035 rx_valid 0xFF during WAIT -> byte not in any block, led[1]=1; the flow completes normally.
REQ-036 With SHA2_RX_TIMEOUT_EN defined and TIMEOUT_CYCLES=100, 3 bytes then 100 idle cycles -> IDLE, led[3]=1; without the macro -> stays in RECV.
REQ-037 rst_n asserted mid-SEND at byte 12 -> all outputs 0 immediately; 16 completed blocks -> led[7:4] wraps to 0.
